// File: rtl/rp_adc_trig_pkg.sv
// Shared constants for the multi-channel ADC threshold trigger.
package rp_adc_trig_pkg;

    localparam int unsigned TRIG_MODE_RISE = 0;
    localparam int unsigned TRIG_MODE_FALL = 1;
    localparam int unsigned TRIG_MODE_W    = 2;

    // Default per-channel slice widths: sample/threshold and holdoff counter.
    localparam int unsigned TRIG_DW_DEF = 14;
    localparam int unsigned TRIG_CH_DEF = 2;
    localparam int unsigned TRIG_HW_DEF = 20;

endpackage

// File: rtl/rp_adc_trig_ch.sv
// One trigger channel: Schmitt detector with prime flag, holdoff and pulse outputs.
// Pipeline: sample/threshold register -> state/candidate register -> pulse register.
module rp_adc_trig_ch
    import rp_adc_trig_pkg::*;
#(
    parameter int unsigned DW = TRIG_DW_DEF,
    parameter int unsigned HW = TRIG_HW_DEF
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic [DW-1:0] i_dat,
    input  logic          i_dv,
    input  logic [DW-1:0] i_tresh,
    input  logic [DW-1:0] i_hyst,
    input  logic [HW-1:0] i_holdoff,
    output logic          o_trig_p,
    output logic          o_trig_n
);

    logic signed [DW:0] r_tresh;
    logic signed [DW:0] r_tp;
    logic signed [DW:0] r_tm;
    logic signed [DW:0] r_dat;
    logic               r_dv;
    logic               r_p;
    logic               r_n;
    logic               r_primed;
    logic               r_cand_p;
    logic               r_cand_n;
    logic               r_trig_p;
    logic               r_trig_n;
    logic [HW-1:0]      r_cnt;

    logic signed [DW:0] w_tresh_x;
    logic signed [DW:0] w_hyst_x;
    logic signed [DW:0] w_dat_x;
    logic               w_p_nxt;
    logic               w_n_nxt;
    logic               w_cnt_zero;
    logic               w_emit_p;
    logic               w_emit_n;

    // One extra bit keeps tresh +/- hyst from wrapping at the rails.
    always_comb begin
        w_tresh_x  = {i_tresh[DW-1], i_tresh};
        w_hyst_x   = {1'b0, i_hyst};
        w_dat_x    = {i_dat[DW-1], i_dat};
        w_p_nxt    = (r_dat >= r_tresh) | (r_p & ~(r_dat < r_tm));
        w_n_nxt    = (r_dat <= r_tresh) | (r_n & ~(r_dat > r_tp));
        w_cnt_zero = (r_cnt == '0);
        w_emit_p   = r_cand_p & w_cnt_zero;
        w_emit_n   = r_cand_n & w_cnt_zero;
    end

    // States are 0 until primed, so the first valid sample loads the raw comparisons.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_tresh  <= '0;
            r_tp     <= '0;
            r_tm     <= '0;
            r_dat    <= '0;
            r_dv     <= 1'b0;
            r_p      <= 1'b0;
            r_n      <= 1'b0;
            r_primed <= 1'b0;
            r_cand_p <= 1'b0;
            r_cand_n <= 1'b0;
            r_trig_p <= 1'b0;
            r_trig_n <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_tresh <= w_tresh_x;
            r_tp    <= w_tresh_x + w_hyst_x;
            r_tm    <= w_tresh_x - w_hyst_x;
            r_dat   <= w_dat_x;
            r_dv    <= i_dv;

            if (r_dv) begin
                r_p      <= w_p_nxt;
                r_n      <= w_n_nxt;
                r_primed <= 1'b1;
                r_cand_p <= r_primed & ~r_p & w_p_nxt;
                r_cand_n <= r_primed & ~r_n & w_n_nxt;
            end else begin
                r_cand_p <= 1'b0;
                r_cand_n <= 1'b0;
            end

            r_trig_p <= w_emit_p;
            r_trig_n <= w_emit_n;
            if (w_emit_p | w_emit_n) begin
                r_cnt <= i_holdoff;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - HW'(1);
            end
        end
    end

    assign o_trig_p = r_trig_p;
    assign o_trig_n = r_trig_n;

endmodule

// File: rtl/rp_adc_trig_mc.sv
// Multi-channel ADC threshold trigger: per-channel detectors plus masked, mode-selected OR.
module rp_adc_trig_mc
    import rp_adc_trig_pkg::*;
#(
    parameter int unsigned DW = TRIG_DW_DEF,
    parameter int unsigned CH = TRIG_CH_DEF,
    parameter int unsigned HW = TRIG_HW_DEF
) (
    input  logic                   adc_clk_i,
    input  logic                   adc_rstn_i,
    input  logic [CH*DW-1:0]       adc_dat_i,
    input  logic [CH-1:0]          adc_dv_i,
    input  logic [CH*DW-1:0]       set_tresh_i,
    input  logic [CH*DW-1:0]       set_hyst_i,
    input  logic [CH*HW-1:0]       set_holdoff_i,
    input  logic [TRIG_MODE_W-1:0] set_mode_i,
    input  logic [CH-1:0]          set_chmask_i,
    output logic [CH-1:0]          adc_trig_p_o,
    output logic [CH-1:0]          adc_trig_n_o,
    output logic                   trig_o
);

    logic [CH-1:0] w_trig_p;
    logic [CH-1:0] w_trig_n;
    logic [CH-1:0] w_hit;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        rp_adc_trig_ch #(
            .DW (DW),
            .HW (HW)
        ) u_ch (
            .adc_clk_i  (adc_clk_i),
            .adc_rstn_i (adc_rstn_i),
            .i_dat      (adc_dat_i[c*DW +: DW]),
            .i_dv       (adc_dv_i[c]),
            .i_tresh    (set_tresh_i[c*DW +: DW]),
            .i_hyst     (set_hyst_i[c*DW +: DW]),
            .i_holdoff  (set_holdoff_i[c*HW +: HW]),
            .o_trig_p   (w_trig_p[c]),
            .o_trig_n   (w_trig_n[c])
        );
    end

    // Combined trigger follows mode/mask changes within the same cycle.
    always_comb begin
        w_hit = set_chmask_i & (({CH{set_mode_i[TRIG_MODE_RISE]}} & w_trig_p) |
                                ({CH{set_mode_i[TRIG_MODE_FALL]}} & w_trig_n));
    end

    assign adc_trig_p_o = w_trig_p;
    assign adc_trig_n_o = w_trig_n;
    assign trig_o       = |w_hit;

endmodule

// File: tb/tb_rp_adc_trig_mc.sv
// Directed-vector bench for rp_adc_trig_mc (DW=14, CH=2, HW=20).
module tb_rp_adc_trig_mc;

    localparam int unsigned DW = 14;
    localparam int unsigned CH = 2;
    localparam int unsigned HW = 20;

    logic             clk;
    logic             rst_n;
    logic [CH*DW-1:0] dat;
    logic [CH-1:0]    dv;
    logic [CH*DW-1:0] tresh;
    logic [CH*DW-1:0] hyst;
    logic [CH*HW-1:0] holdoff;
    logic [1:0]       mode;
    logic [CH-1:0]    mask;
    logic [CH-1:0]    p;
    logic [CH-1:0]    n;
    logic             trig;

    typedef struct {
        logic signed [DW-1:0] d0;
        logic signed [DW-1:0] d1;
        logic [1:0]           dv;
        logic [1:0]           ep;
        logic [1:0]           en;
        logic                 et;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    rp_adc_trig_mc #(.DW(DW), .CH(CH), .HW(HW)) dut (
        .adc_clk_i     (clk),
        .adc_rstn_i    (rst_n),
        .adc_dat_i     (dat),
        .adc_dv_i      (dv),
        .set_tresh_i   (tresh),
        .set_hyst_i    (hyst),
        .set_holdoff_i (holdoff),
        .set_mode_i    (mode),
        .set_chmask_i  (mask),
        .adc_trig_p_o  (p),
        .adc_trig_n_o  (n),
        .trig_o        (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic add(input int d0, input int d1, input logic [1:0] dv_v,
                       input logic [1:0] ep, input logic [1:0] en, input logic et);
        vec_t v;
        v.d0 = DW'(d0);
        v.d1 = DW'(d1);
        v.dv = dv_v;
        v.ep = ep;
        v.en = en;
        v.et = et;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] ep,
                         input logic [1:0] en, input logic et);
        n_tests++;
        if ({p, n, trig} !== {ep, en, et}) begin
            n_fail++;
            $display("FAIL %s: got p=%b n=%b trig=%b, want p=%b n=%b trig=%b",
                     name, p, n, trig, ep, en, et);
        end
    endtask

    task automatic cfg(input int t, input int h, input int ho);
        tresh   = {DW'(t), DW'(t)};
        hyst    = {DW'(h), DW'(h)};
        holdoff = {HW'(ho), HW'(ho)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        dv    = '0;
        rst_n = 1'b0;
        #1;
        check("reset_hold", 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            dat = {vq[i].d1, vq[i].d0};
            dv  = vq[i].dv;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", name, i), vq[i].ep, vq[i].en, vq[i].et);
        end
        vq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        dat   = '0;
        dv    = '0;
        mode  = 2'b11;
        mask  = 2'b11;
        cfg(100, 20, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 2'b00, 2'b00, 1'b0);

        // Ramp 0->200->0 on ch0: rise seen 2 clocks after ascending 100, fall after descending 100.
        cfg(100, 20, 0);
        do_reset();
        for (int i = 0; i <= 42; i++) begin
            int s;
            s = (i <= 20) ? 10 * i : ((i <= 40) ? 200 - 10 * (i - 20) : 0);
            add(s, 0, 2'b01, (i == 12) ? 2'b01 : 2'b00, (i == 32) ? 2'b01 : 2'b00,
                (i == 12) || (i == 32));
        end
        run("ramp");

        // Hysteresis: 85 does not re-arm, 70 does.
        cfg(100, 20, 0);
        do_reset();
        add(90,  0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(100, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(85,  0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(100, 0, 2'b01, 2'b01, 2'b00, 1'b1);
        add(70,  0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(100, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(100, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(100, 0, 2'b01, 2'b01, 2'b00, 1'b1);
        run("hyst");

        // Holdoff 5 with 0/200 toggling: rising pulses every 6 cycles, all falls dropped.
        cfg(100, 20, 5);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            logic hit;
            hit = (i == 3) || (i == 9) || (i == 15) || (i == 21);
            add((i % 2 == 1) ? 200 : 0, 0, 2'b01, hit ? 2'b01 : 2'b00, 2'b00, hit);
        end
        run("holdoff");

        // Positive rail: tp must not wrap.
        cfg(8191, 100, 0);
        do_reset();
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(8191,  0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(8191,  0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(8191,  0, 2'b01, 2'b01, 2'b00, 1'b1);
        run("wrap_hi");

        // Negative rail: falling state clears only above tp=-8092.
        cfg(-8192, 100, 0);
        do_reset();
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8092, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8091, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(-8192, 0, 2'b01, 2'b00, 2'b01, 1'b1);
        add(-8192, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        run("wrap_lo");

        // Prime on 200 gives no pulse; crossings while dv is low are ignored.
        cfg(100, 20, 0);
        do_reset();
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b00, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b00, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        run("prime_dv");

        // Reset during a pulse and a long holdoff clears everything immediately.
        cfg(100, 20, 50);
        do_reset();
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b01, 2'b01, 2'b00, 1'b1);
        run("pre_rst");
        rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        dv    = '0;
        rst_n = 1'b1;
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(200, 0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b01, 2'b01, 2'b00, 1'b1);
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        add(0,   0, 2'b01, 2'b00, 2'b00, 1'b0);
        run("post_rst");

        // Two channels crossing opposite ways in the same cycle; only ch0 fall is enabled.
        cfg(100, 20, 0);
        mode = 2'b10;
        mask = 2'b01;
        do_reset();
        add(200, 0,   2'b11, 2'b00, 2'b00, 1'b0);
        add(0,   200, 2'b11, 2'b00, 2'b00, 1'b0);
        add(0,   200, 2'b11, 2'b00, 2'b00, 1'b0);
        add(0,   200, 2'b11, 2'b10, 2'b01, 1'b1);
        run("multi");
        mask = 2'b00;
        #1;
        check("mask_off_same_cycle", 2'b10, 2'b01, 1'b0);
        mask = 2'b10;
        mode = 2'b01;
        #1;
        check("ch1_rise_same_cycle", 2'b10, 2'b01, 1'b1);
        mode = 2'b00;
        #1;
        check("mode_off_same_cycle", 2'b10, 2'b01, 1'b0);
        @(posedge clk);
        #1;
        check("multi_after", 2'b00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
